// File: rtl/cmpeq_bist_ctrl_pkg.sv
// Shared types and defaults for the cmpeq BIST controller.
package cmpeq_bist_pkg;

  // Pattern width for the 2-bit equality comparator: {a[1:0], b[1:0]}.
  localparam int unsigned DEFAULT_PW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

endpackage

// File: rtl/cmpeq_bist_ctrl_if.sv
// Pattern/response bundle between the BIST controller and the comparator side.
interface cmpeq_bist_ctrl_if
  import cmpeq_bist_pkg::*;
#(
  parameter int unsigned PW = DEFAULT_PW
);
  localparam int unsigned NP = 1 << PW;

  logic            start;
  logic            step_en;
  logic [NP-1:0]   golden;
  logic            resp;
  logic [PW-1:0]   pattern;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NP-1:0]   respvec;
  logic [PW:0]     ones;

  // Stimulus/netlist side: issues commands, returns the comparator output.
  modport master (
    output start, step_en, golden, resp,
    input  pattern, busy, done, pass, respvec, ones
  );

  // Controller side.
  modport slave (
    input  start, step_en, golden, resp,
    output pattern, busy, done, pass, respvec, ones
  );
endinterface

// File: rtl/cmpeq_bist_ctrl_pat_counter.sv
// PW-bit pattern counter with synchronous clear, enable and terminal-count flag.
module bist_pat_counter #(
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [PW-1:0] o_cnt,
  output logic          o_tc
);

  logic [PW-1:0] r_cnt;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = &r_cnt;

endmodule

// File: rtl/cmpeq_bist_ctrl.sv
// Exhaustive pattern source and response collector for the cmpeq netlist.
// Steps {a,b} through all NP values, captures the comparator output per
// pattern, counts ones and compares the bitmap against a golden vector.
module cmpeq_bist_ctrl
  import cmpeq_bist_pkg::*;
#(
  parameter int unsigned PW = DEFAULT_PW
) (
  input logic              clk,
  input logic              rst,
  cmpeq_bist_ctrl_if.slave bus
);

  localparam int unsigned NP = 1 << PW;

  bist_state_t   r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [NP-1:0] r_respvec;
  logic [PW:0]   r_ones;

  logic          w_clr;
  logic          w_step;
  logic          w_cnt_en;
  logic [PW-1:0] w_cnt;
  logic          w_tc;
  logic [NP-1:0] w_capture;

  assign w_clr    = (r_state != RUN) && bus.start;
  assign w_step   = (r_state == RUN) && bus.step_en;
  // The counter parks on NP-1 so the last pattern stays on the bus in DONE.
  assign w_cnt_en = w_step && !w_tc;

  bist_pat_counter #(
    .PW (PW)
  ) u_pat_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // Bitmap with the current response merged in; on the last step this is
  // the final bitmap, so the pass compare sees the last bit in the same edge.
  always_comb begin
    w_capture        = r_respvec;
    w_capture[w_cnt] = bus.resp;
  end

  // Run-control FSM with registered status, capture and ones counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_respvec <= '0;
      r_ones    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_respvec <= '0;
            r_ones    <= '0;
          end
        end
        RUN: begin
          if (bus.step_en) begin
            r_respvec <= w_capture;
            r_ones    <= r_ones + {{PW{1'b0}}, bus.resp};
            if (w_tc) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_capture == bus.golden);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern = w_cnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.respvec = r_respvec;
  assign bus.ones    = r_ones;

endmodule

// File: tb/tb_cmpeq_bist_ctrl.sv
// Self-checking bench for cmpeq_bist_ctrl with a behavioural comparator netlist
// (good / stuck-at-0 / stuck-at-1 / arbitrary truth table) and run-level model.
module tb_cmpeq_bist_ctrl;
  import cmpeq_bist_pkg::*;

  localparam int unsigned PW = 4;
  localparam int unsigned NP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmpeq_bist_ctrl_if #(.PW(PW)) bus ();

  cmpeq_bist_ctrl #(.PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          fault_mode = 0;
  logic [15:0] tt = '0;

  // Comparator netlist under test, possibly with a planted fault.
  always_comb begin
    case (fault_mode)
      1:       bus.resp = 1'b0;
      2:       bus.resp = 1'b1;
      3:       bus.resp = tt[bus.pattern];
      default: bus.resp = (bus.pattern[3:2] == bus.pattern[1:0]);
    endcase
  end

  // Expected comparator output for pattern index i, from {a,b} arithmetic.
  function automatic logic model_bit(input int mode, input logic [15:0] t, input int i);
    int a, b;
    a = i / 4;
    b = i % 4;
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return t[i];
      default: return (a == b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pattern"}, 32'(bus.pattern), 0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
    chk({tag, "_done"},    32'(bus.done),    0);
    chk({tag, "_pass"},    32'(bus.pass),    0);
    chk({tag, "_respvec"}, 32'(bus.respvec), 0);
    chk({tag, "_ones"},    32'(bus.ones),    0);
  endtask

  // One BIST run. Called 1ns after a rising edge; returns 1ns after an edge.
  task automatic run(input string tag, input int mode, input logic [15:0] t,
                     input logic [15:0] gold, input int stall_lo, input int stall_hi,
                     input bit rnd_stall, input int start_pulse_cyc, input int abort_step);
    logic [15:0] exp_vec;
    logic [15:0] part;
    int          exp_ones;
    int          nsteps;
    int          cyc;
    int          stalls;
    bit          en;
    bit          finished;
    bit          aborted;

    fault_mode = mode;
    tt         = t;
    exp_ones   = 0;
    for (int i = 0; i < int'(NP); i++) begin
      exp_vec[i] = model_bit(mode, t, i);
      if (exp_vec[i]) exp_ones++;
    end

    bus.golden  = gold;
    bus.step_en = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_entry_busy"},    32'(bus.busy),    1);
    chk({tag, "_entry_pattern"}, 32'(bus.pattern), 0);
    chk({tag, "_entry_done"},    32'(bus.done),    0);
    chk({tag, "_entry_respvec"}, 32'(bus.respvec), 0);
    chk({tag, "_entry_ones"},    32'(bus.ones),    0);

    nsteps   = 0;
    cyc      = 1;
    stalls   = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    while (!finished && cyc < 200) begin
      if (abort_step >= 0 && nsteps == abort_step) begin
        chk({tag, "_abort_pattern"}, 32'(bus.pattern), 32'(abort_step));
        #2 rst = 1'b1;
        #1 chk_all_zero({tag, "_abort_async"});
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk_all_zero({tag, "_abort_idle"});
        aborted  = 1'b1;
        finished = 1'b1;
      end else begin
        en = 1'b1;
        if (cyc >= stall_lo && cyc <= stall_hi) en = 1'b0;
        if (rnd_stall && $urandom_range(3) == 0) en = 1'b0;
        if (!en) stalls++;
        bus.step_en = en;
        bus.start   = (cyc == start_pulse_cyc);
        @(posedge clk);
        if (en) nsteps++;
        #1;
        bus.start = 1'b0;
        cyc++;
        if (nsteps == int'(NP)) begin
          finished = 1'b1;
          chk({tag, "_done"},      32'(bus.done),    1);
          chk({tag, "_busy_low"},  32'(bus.busy),    0);
          chk({tag, "_done_edge"}, 32'(cyc),         32'(1 + NP + stalls));
          chk({tag, "_respvec"},   32'(bus.respvec), 32'(exp_vec));
          chk({tag, "_ones"},      32'(bus.ones),    32'(exp_ones));
          chk({tag, "_pass"},      32'(bus.pass),    32'(exp_vec == gold));
          chk({tag, "_last_pat"},  32'(bus.pattern), NP - 1);
        end else begin
          part = '0;
          for (int i = 0; i < nsteps; i++) part[i] = exp_vec[i];
          chk({tag, "_run_busy"},    32'(bus.busy),    1);
          chk({tag, "_run_done"},    32'(bus.done),    0);
          chk({tag, "_run_pattern"}, 32'(bus.pattern), 32'(nsteps));
          chk({tag, "_run_ones"},    32'(bus.ones),    32'($countones(part)));
        end
      end
    end
    if (!finished) chk({tag, "_timeout"}, 0, 1);
    if (finished && !aborted) begin
      // Done must hold while start stays low.
      bus.step_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_done_hold"}, 32'(bus.done), 1);
    end
    bus.step_en = 1'b1;
  endtask

  initial begin
    logic [15:0] rt;
    logic [15:0] rg;
    int          rm;

    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.step_en = 1'b1;
    bus.golden  = 16'h8421;

    // Asynchronous reset mid-cycle clears outputs before any edge.
    #2 rst = 1'b1;
    #1 chk_all_zero("reset_async");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 0 || i == 19) chk_all_zero("idle");
    end

    run("good",   0, '0, 16'h8421, 0, -1, 1'b0, -1, -1);
    run("sa0",    1, '0, 16'h8421, 0, -1, 1'b0, -1, -1);
    run("sa1",    2, '0, 16'h8421, 0, -1, 1'b0, -1, -1);
    run("stall",  0, '0, 16'h8421, 3,  5, 1'b0, -1, -1);
    run("ignst",  0, '0, 16'h8421, 0, -1, 1'b0,  5, -1);
    run("abort",  0, '0, 16'h8421, 0, -1, 1'b0, -1,  7);
    run("rerun",  0, '0, 16'h8421, 0, -1, 1'b0, -1, -1);

    for (int k = 0; k < 6; k++) begin
      rm = int'($urandom_range(3));
      rt = 16'($urandom);
      rg = 16'($urandom);
      if (k % 2 == 0) begin
        for (int i = 0; i < int'(NP); i++) rg[i] = model_bit(rm, rt, i);
      end
      run("rand", rm, rt, rg, 0, -1, 1'b1, int'($urandom_range(20)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
